// File: rtl/centimospaeuros.sv
// centimospaeuros: converts cents to whole euros and cent remainder
// with a restoring divide-by-100, one quotient bit per clock.
// Optional BCD outputs are built when CENTIMOSPAEUROS_BCD_EN is defined.
module centimospaeuros #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] centimos,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] eurosinteiros,
    output logic [W-1:0] eurosfracao
`ifdef CENTIMOSPAEUROS_BCD_EN
    ,
    output logic [7:0]   bcd_int,
    output logic [7:0]   bcd_frac
`endif
);

    localparam logic [W-1:0] DIV = W'(100);
    localparam int CW = $clog2(W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        nstate;
    logic [W-1:0]  dvd;
    logic [W-1:0]  rem;
    logic [W-1:0]  rem_sh;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  dvd_nx;
    logic          qbit;
    logic [CW-1:0] cnt;
    logic          last;

    // one restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem[W-2:0], dvd[W-1]};
        qbit   = (rem_sh >= DIV);
        rem_nx = qbit ? (rem_sh - DIV) : rem_sh;
        dvd_nx = {dvd[W-2:0], qbit};
        last   = (cnt == CW'(W - 1));
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // next-state logic; start is only honoured while idle
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last)  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // state-derived outputs
    always_comb begin
        busy = (state == RUN);
    end

    // divider datapath; dividend register collects the quotient bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            dvd <= centimos;
            rem <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            dvd <= dvd_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
        end
    end

    // results and done pulse, updated only on the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done          <= 1'b0;
            eurosinteiros <= '0;
            eurosfracao   <= '0;
        end else begin
            done <= 1'b0;
            if (state == RUN && last) begin
                done          <= 1'b1;
                eurosinteiros <= dvd_nx;
                eurosfracao   <= rem_nx;
            end
        end
    end

`ifdef CENTIMOSPAEUROS_BCD_EN
    // two-digit BCD copies of the results, same update edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_int  <= '0;
            bcd_frac <= '0;
        end else if (state == RUN && last) begin
            bcd_int  <= {4'(dvd_nx / W'(10)), 4'(dvd_nx % W'(10))};
            bcd_frac <= {4'(rem_nx / W'(10)), 4'(rem_nx % W'(10))};
        end
    end
`endif

endmodule

// File: tb/tb_centimospaeuros.sv
// tb_centimospaeuros: scoreboard bench for the cents-to-euros divider.
// Stimulus pushes expected results; a monitor pops them on each done.
module tb_centimospaeuros;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] centimos = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] ei;
    logic [W-1:0] ef;
`ifdef CENTIMOSPAEUROS_BCD_EN
    logic [7:0]   bcd_int;
    logic [7:0]   bcd_frac;
`endif

    centimospaeuros #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .centimos      (centimos),
        .busy          (busy),
        .done          (done),
        .eurosinteiros (ei),
        .eurosfracao   (ef)
`ifdef CENTIMOSPAEUROS_BCD_EN
        ,
        .bcd_int       (bcd_int),
        .bcd_frac      (bcd_frac)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    logic [2*W-1:0] sb[$];
    logic [W-1:0] held_i = '0;
    logic [W-1:0] held_f = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, req);
    endtask

    // monitor: every done must match the oldest expected result
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("euros_int", 32'(ei), 32'(e[2*W-1:W]));
                check("euros_frac", 32'(ef), 32'(e[W-1:0]));
            end
        end
    end

    task automatic convert(input logic [W-1:0] c,
                           input logic [W-1:0] ie,
                           input logic [W-1:0] fe);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        centimos = c;
        sb.push_back({ie, fe});
        @(posedge clk);
        #1;
        start    = 1'b0;
        centimos = ~c;
        lat = 0;
        while (!done && lat < 20) begin
            check("busy_during", 32'(busy), 32'd1);
            check("hold_int", 32'(ei), 32'(held_i));
            check("hold_frac", 32'(ef), 32'(held_f));
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(W));
        check("busy_after", 32'(busy), 32'd0);
        held_i = ie;
        held_f = fe;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    int perm[1024];

    initial begin
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_int", 32'(ei), 32'd0);
        check("rst_frac", 32'(ef), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        convert(10'd470, 10'd4, 10'd70);
        convert(10'd0, 10'd0, 10'd0);
        convert(10'd99, 10'd0, 10'd99);
        convert(10'd100, 10'd1, 10'd0);
        convert(10'd1023, 10'd10, 10'd23);
`ifdef CENTIMOSPAEUROS_BCD_EN
        check("bcd_int", 32'(bcd_int), 32'h10);
        check("bcd_frac", 32'(bcd_frac), 32'h23);
`endif
        // back-to-back: starts on the cycle right after done
        convert(10'd205, 10'd2, 10'd5);

        // start ignored while busy and on the done edge
        @(negedge clk);
        start    = 1'b1;
        centimos = 10'd470;
        sb.push_back({10'd4, 10'd70});
        @(posedge clk);
        #1;
        for (int k = 0; k < W; k++) begin
            check("busy_cont", 32'(busy), 32'd1);
            start    = (k == 3 || k == W - 1);
            centimos = 10'd250;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("done_ign", 32'(done), 32'd1);
        check("busy_ign", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("idle_ign", 32'(busy), 32'd0);
        held_i = 10'd4;
        held_f = 10'd70;

        // asynchronous reset mid-conversion
        @(negedge clk);
        start    = 1'b1;
        centimos = 10'd470;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_int", 32'(ei), 32'd0);
        check("arst_frac", 32'(ef), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        held_i = '0;
        held_f = '0;
        repeat (15) @(posedge clk);
        #1;
        check("arst_idle", 32'(busy), 32'd0);
        convert(10'd305, 10'd3, 10'd5);

        // every input once, in shuffled order
        for (int i = 0; i < 1024; i++) perm[i] = i;
        for (int i = 1023; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 1024; i++) begin
            logic [W-1:0] c;
            c = W'(perm[i]);
            convert(c, W'(c / 100), W'(c % 100));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
